serial_parity_checker: RTL

//  Deframes a serial bit stream into DATA_BITS-wide words and checks the trailing parity bit.
//  The parity is a running XOR over data and parity bits.

---
 rtl/parity_pkg.sv | 9 +
 rtl/serial_parity_checker_acc.sv | 29 ++
 rtl/serial_parity_checker.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared state encoding and parity-sense constants for the serial parity checker.
package parity_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, REPORT} pchk_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_acc.sv
// 1-bit registered XOR accumulator built from 2:1 mux selections and constants.
module parity_bit_acc (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);

   logic q_q, q_d;
   logic xor_w, run_w, load_w;

   // clr restarts the sum, seeding it with d when en is also set.
   always_comb begin
      xor_w  = q_q ^ d;
      run_w  = en  ? xor_w : q_q;
      load_w = en  ? d     : 1'b0;
      q_d    = clr ? load_w : run_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deframes an LSB-first serial stream into DATA_BITS words and flags trailing-parity errors.
module serial_parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int ODD_PARITY     = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_bit,
   input  logic                 in_first,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_perr,
   output logic                 frame_abort
);

   localparam int   CW      = $clog2(DATA_BITS + 1);
   localparam int   TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic PAR_REF = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

   pchk_state_t          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_perr_q, out_perr_d;
   logic                 abort_q, abort_d;
   logic                 acc_q, acc_clr, acc_en;
   logic                 beat, start;

   parity_bit_acc u_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (acc_en),
      .d   (in_bit),
      .q   (acc_q)
   );

   always_comb begin
      beat        = in_valid && (state_q != REPORT);
      start       = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      shreg_d     = shreg_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_perr_d  = out_perr_q;
      abort_d     = 1'b0;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;

      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (beat && in_first) start = 1'b1;
         end
         DATA, PARITY: begin
            if (beat) begin
               tmo_d = '0;
               if (state_q == DATA && in_first) begin
                  start   = 1'b1;
                  abort_d = 1'b1;
               end else if (state_q == DATA) begin
                  acc_en = 1'b1;
                  for (int i = 0; i < DATA_BITS; i++) begin
                     if (cnt_q == CW'(i)) shreg_d[i] = in_bit;
                  end
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_d == CW'(DATA_BITS)) state_d = PARITY;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = shreg_q;
                  out_perr_d  = ((acc_q ^ in_bit) != PAR_REF);
                  cnt_d       = '0;
                  state_d     = REPORT;
               end
            // The idle counter stops one short of the limit, so it never needs to hold TIMEOUT_CYCLES.
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               abort_d = 1'b1;
               tmo_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         REPORT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         shreg_d    = '0;
         shreg_d[0] = in_bit;
         acc_clr    = 1'b1;
         acc_en     = 1'b1;
         cnt_d      = CW'(1);
         state_d    = (DATA_BITS == 1) ? PARITY : DATA;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tmo_q       <= '0;
         shreg_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_perr_q  <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         shreg_q     <= shreg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_perr_q  <= out_perr_d;
         abort_q     <= abort_d;
      end
   end

   assign in_ready    = (state_q != REPORT);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_perr    = out_perr_q;
   assign frame_abort = abort_q;

endmodule
